// File: rtl/hist_pkg.sv
// hist_pkg: shared types, default parameters and the saturating-increment
// helper for the histogram engine.
//   hist_state_t : engine mode (clear sweep / run)
//   DEF_*        : default widths used by histogram_engine
//   sat_inc      : value + 1, clamped at max_value (widths up to 32 bits)
package hist_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } hist_state_t;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_BIN_W = 8;
  localparam int unsigned DEF_CNT_W = 20;
  localparam int unsigned DEF_TOT_W = 32;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// hist_bin_ram: 2**ADDR_W x DATA_W bin storage. One write port, two
// synchronous read ports with read-first behaviour on address collision.
// No reset; contents are initialised by the engine's clear sweep.
//   clk       : clock, rising edge
//   we        : write enable
//   wr_addr   : write address
//   wr_data   : write data
//   rd_a_addr : read port A address (pipeline read)
//   rd_a_data : read port A data, one cycle after address
//   rd_b_addr : read port B address (readout)
//   rd_b_data : read port B data, one cycle after address
module hist_bin_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_a_data <= mem[rd_a_addr];
    rd_b_data <= mem[rd_b_addr];
  end

endmodule

// File: rtl/histogram_engine.sv
// histogram_engine: streaming gray-level histogram. Each accepted pixel is
// binned by its top BIN_W bits and its bin counter is read-modify-written
// (saturating) through a 3-stage pipeline with same-bin forwarding, so one
// pixel per clock is sustained. A self-timed sweep zeroes all bins after
// reset or on iClear.
//   iClk     : clock, rising edge
//   iRst_n   : asynchronous active-low reset
//   iClear   : one-cycle request to start (or restart) a clear sweep
//   iValid   : pixel strobe, accepted when oReady is high
//   iGray    : pixel value
//   oReady   : high in run mode
//   oBusy    : high while sweeping
//   oDone    : one-cycle pulse when a sweep completes
//   iRdAddr  : readout bin index
//   oRdData  : registered count of iRdAddr (2-cycle latency)
//   oTotal   : accepted pixels since last clear, saturating
module histogram_engine
  import hist_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned BIN_W = DEF_BIN_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned TOT_W = DEF_TOT_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iClear,
  input  logic             iValid,
  input  logic [PIX_W-1:0] iGray,
  output logic             oReady,
  output logic             oBusy,
  output logic             oDone,
  input  logic [BIN_W-1:0] iRdAddr,
  output logic [CNT_W-1:0] oRdData,
  output logic [TOT_W-1:0] oTotal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  hist_state_t      state, state_nxt;
  logic             done_nxt;
  logic [BIN_W-1:0] sweep_addr;

  logic             accept;
  logic [BIN_W-1:0] pix_bin;

  // S1: read data returning; S2: write register; cw: write committed last edge
  logic             s1_valid;
  logic [BIN_W-1:0] s1_bin;
  logic [CNT_W-1:0] s1_src;
  logic [CNT_W-1:0] s1_next;
  logic             s2_valid;
  logic [BIN_W-1:0] s2_bin;
  logic [CNT_W-1:0] s2_data;
  logic             cw_valid;
  logic [BIN_W-1:0] cw_bin;
  logic [CNT_W-1:0] cw_data;

  logic             ram_we;
  logic [BIN_W-1:0] ram_wr_addr;
  logic [CNT_W-1:0] ram_wr_data;
  logic [CNT_W-1:0] ram_rd_a_data;
  logic [CNT_W-1:0] ram_rd_b_data;

  assign pix_bin = iGray[PIX_W-1 -: BIN_W];
  assign accept  = iValid & oReady;

  // ---------------- FSM ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      oDone      <= 1'b0;
    end else begin
      state <= state_nxt;
      oDone <= done_nxt;
      if (iClear) begin
        sweep_addr <= '0;
      end else if (state == ST_CLEAR) begin
        sweep_addr <= sweep_addr + BIN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    oReady    = 1'b0;
    oBusy     = 1'b0;
    case (state)
      ST_CLEAR: begin
        oBusy = 1'b1;
        // A clear request mid-sweep restarts it; the aborted sweep never reports done.
        if (!iClear && sweep_addr == '1) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        oReady = 1'b1;
        if (iClear) begin
          state_nxt = ST_CLEAR;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // ---------------- RMW pipeline ----------------
  // Newest data wins: S2 holds the write about to commit, cw holds the write
  // the read-first RAM missed by one cycle.
  always_comb begin
    s1_src = ram_rd_a_data;
    if (s2_valid && s2_bin == s1_bin) begin
      s1_src = s2_data;
    end else if (cw_valid && cw_bin == s1_bin) begin
      s1_src = cw_data;
    end
    s1_next = CNT_W'(sat_inc(32'(s1_src), 32'(CNT_MAX)));
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_data  <= '0;
      cw_valid <= 1'b0;
      cw_bin   <= '0;
      cw_data  <= '0;
    end else if (iClear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      cw_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_bin   <= pix_bin;
      s2_valid <= s1_valid;
      s2_bin   <= s1_bin;
      s2_data  <= s1_next;
      cw_valid <= s2_valid;
      cw_bin   <= s2_bin;
      cw_data  <= s2_data;
    end
  end

  always_comb begin
    if (state == ST_CLEAR) begin
      ram_we      = 1'b1;
      ram_wr_addr = sweep_addr;
      ram_wr_data = '0;
    end else begin
      ram_we      = s2_valid;
      ram_wr_addr = s2_bin;
      ram_wr_data = s2_data;
    end
  end

  hist_bin_ram #(
    .ADDR_W (BIN_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk       (iClk),
    .we        (ram_we),
    .wr_addr   (ram_wr_addr),
    .wr_data   (ram_wr_data),
    .rd_a_addr (pix_bin),
    .rd_a_data (ram_rd_a_data),
    .rd_b_addr (iRdAddr),
    .rd_b_data (ram_rd_b_data)
  );

  // ---------------- readout and total ----------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdData <= '0;
      oTotal  <= '0;
    end else begin
      oRdData <= ram_rd_b_data;
      if (iClear) begin
        oTotal <= '0;
      end else if (accept) begin
        oTotal <= TOT_W'(sat_inc(32'(oTotal), 32'(TOT_MAX)));
      end
    end
  end

endmodule

// File: tb/tb_histogram_engine.sv
module tb_histogram_engine;

  localparam int unsigned NB = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, valid;
  logic [7:0]  gray, rd_addr;
  logic        ready, busy, done;
  logic [19:0] rd_data;
  logic [31:0] total;

  logic        s_clear, s_valid;
  logic [7:0]  s_gray, s_rd_addr;
  logic        s_ready, s_busy, s_done;
  logic [3:0]  s_rd_data;
  logic [31:0] s_total;

  always #5 clk = ~clk;

  histogram_engine dut (
    .iClk(clk), .iRst_n(rst_n), .iClear(clear), .iValid(valid), .iGray(gray),
    .oReady(ready), .oBusy(busy), .oDone(done), .iRdAddr(rd_addr),
    .oRdData(rd_data), .oTotal(total)
  );

  histogram_engine #(.CNT_W(4)) dut_sat (
    .iClk(clk), .iRst_n(rst_n), .iClear(s_clear), .iValid(s_valid), .iGray(s_gray),
    .oReady(s_ready), .oBusy(s_busy), .oDone(s_done), .iRdAddr(s_rd_addr),
    .oRdData(s_rd_data), .oTotal(s_total)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one counter per bin plus the accepted-pixel total
  int unsigned model_bin[NB];
  int unsigned model_tot;

  typedef struct {
    logic [7:0]  gray;
    int unsigned n;
    logic [7:0]  addr;
    int unsigned exp_cnt;
    int unsigned exp_tot;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges);
    for (edges = 1; edges <= 600; edges++) begin
      tick();
      if (done === 1'b1) break;
    end
  endtask

  task automatic read_bin(input logic [7:0] a, output logic [19:0] d);
    rd_addr = a;
    tick();
    tick();
    d = rd_data;
  endtask

  task automatic do_clear(input string name);
    int e;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'(1));
    chk({name, "_ready"}, 64'(ready), 64'(0));
    wait_done(e);
    chk({name, "_sweep_len"}, 64'(e), 64'(256));
    for (int b = 0; b < int'(NB); b++) model_bin[b] = 0;
    model_tot = 0;
  endtask

  task automatic send(input logic [7:0] g);
    valid = 1'b1;
    gray  = g;
    tick();
    valid = 1'b0;
  endtask

  task automatic count_nonzero(output int nz);
    logic [19:0] d;
    nz = 0;
    for (int b = 0; b < int'(NB); b++) begin
      read_bin(8'(b), d);
      if (d != 0) nz++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int e, nz, pulses;
    logic [19:0] d;
    logic [7:0] pat[4];

    vecs[0] = '{gray: 8'h37, n: 10, addr: 8'h37, exp_cnt: 10, exp_tot: 10};
    vecs[1] = '{gray: 8'h00, n: 1,  addr: 8'h00, exp_cnt: 1,  exp_tot: 1};
    vecs[2] = '{gray: 8'hFF, n: 3,  addr: 8'hFF, exp_cnt: 3,  exp_tot: 3};
    vecs[3] = '{gray: 8'h80, n: 5,  addr: 8'h81, exp_cnt: 0,  exp_tot: 5};
    vecs[4] = '{gray: 8'h37, n: 0,  addr: 8'h37, exp_cnt: 0,  exp_tot: 0};

    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; gray = '0; rd_addr = '0;
    s_clear = 1'b0; s_valid = 1'b0; s_gray = '0; s_rd_addr = '0;
    for (int b = 0; b < int'(NB); b++) model_bin[b] = 0;
    model_tot = 0;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rddata", 64'(rd_data), 64'(0));
    chk("rst_total", 64'(total), 64'(0));

    // initial sweep
    rst_n = 1'b1;
    wait_done(e);
    chk("init_sweep_len", 64'(e), 64'(256));
    chk("init_ready", 64'(ready), 64'(1));
    chk("init_busy", 64'(busy), 64'(0));
    chk("init_sat_done", 64'(s_done), 64'(1));
    tick();
    chk("done_pulse_width", 64'(done), 64'(0));
    count_nonzero(nz);
    chk("init_bins_zero", 64'(nz), 64'(0));

    // table-driven bursts, each from a freshly cleared histogram
    for (int i = 0; i < 5; i++) begin
      do_clear($sformatf("vec%0d_clr", i));
      for (int k = 0; k < int'(vecs[i].n); k++) send(vecs[i].gray);
      repeat (3) tick();
      read_bin(vecs[i].addr, d);
      chk($sformatf("vec%0d_bin", i), 64'(d), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_total", i), 64'(total), 64'(vecs[i].exp_tot));
    end

    // alternating pattern: forwarding at distance 1 and 2
    do_clear("alt_clr");
    pat[0] = 8'h05; pat[1] = 8'h05; pat[2] = 8'h09; pat[3] = 8'h05;
    valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      gray = pat[c % 4];
      tick();
    end
    valid = 1'b0;
    repeat (3) tick();
    read_bin(8'h05, d);
    chk("alt_bin5", 64'(d), 64'(75));
    read_bin(8'h09, d);
    chk("alt_bin9", 64'(d), 64'(25));
    chk("alt_total", 64'(total), 64'(100));

    // clear while pixels in flight, valid held high through the sweep
    valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      gray = 8'($urandom_range(0, 255));
      tick();
    end
    gray  = 8'h60;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("flight_busy", 64'(busy), 64'(1));
    chk("flight_total_reset", 64'(total), 64'(0));
    wait_done(e);
    valid = 1'b0;
    chk("flight_sweep_len", 64'(e), 64'(256));
    chk("flight_total_at_done", 64'(total), 64'(0));
    repeat (3) tick();
    count_nonzero(nz);
    chk("flight_bins_zero", 64'(nz), 64'(0));
    chk("flight_total_after", 64'(total), 64'(0));

    // clear request mid-sweep restarts without a done pulse
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("restart_no_done", 64'(pulses), 64'(0));
    wait_done(e);
    chk("restart_sweep_len", 64'(e), 64'(256));

    // randomized stream against the model: first a few hot bins, then full range
    for (int b = 0; b < int'(NB); b++) model_bin[b] = 0;
    model_tot = 0;
    for (int c = 0; c < 2000; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      gray  = (c < 1000) ? 8'($urandom_range(16, 18)) : 8'($urandom_range(0, 255));
      if (valid) begin
        model_bin[gray] = model_bin[gray] + 1;
        model_tot = model_tot + 1;
      end
      tick();
      if (c % 50 == 49) chk($sformatf("rand_total@%0d", c), 64'(total), 64'(model_tot));
    end
    valid = 1'b0;
    repeat (3) tick();
    for (int b = 0; b < int'(NB); b++) begin
      read_bin(8'(b), d);
      chk($sformatf("rand_bin[%0d]", b), 64'(d), 64'(model_bin[b]));
    end

    // saturation with a 4-bit counter
    s_valid = 1'b1;
    s_gray  = 8'hFF;
    repeat (20) tick();
    s_valid = 1'b0;
    repeat (3) tick();
    s_rd_addr = 8'hFF;
    tick(); tick();
    chk("sat_bin_ff", 64'(s_rd_data), 64'(15));
    s_rd_addr = 8'hFE;
    tick(); tick();
    chk("sat_bin_fe", 64'(s_rd_data), 64'(0));
    chk("sat_total", 64'(s_total), 64'(20));

    // reset mid-stream
    valid = 1'b1;
    gray  = 8'h20;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(1));
    chk("midrst_total", 64'(total), 64'(0));
    chk("midrst_rddata", 64'(rd_data), 64'(0));
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_done(e);
    chk("midrst_sweep_len", 64'(e), 64'(256));
    read_bin(8'h20, d);
    chk("midrst_bin20", 64'(d), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_engine.md
# histogram_engine

Parametrised streaming histogram accumulator for the gray-level processing chain. Bins each accepted pixel by its top `BIN_W` bits and read-modify-writes a saturating per-bin counter in internal block RAM, one pixel per clock with full same-bin forwarding. It provides a self-timed clear sweep with busy/done handshake, an independent registered readout port for downstream CDF/equalisation logic, and a saturating total-pixel counter.

## Interface
- `PIX_W`, 8: input pixel width.
- `BIN_W`, 8: bin index width; `NBINS = 2**BIN_W`; `BIN_W <= PIX_W`.
- `CNT_W`, 20: per-bin counter width.
- `TOT_W`, 32: total-pixel counter width.
- `iClk`  in  1  sole clock, rising edge.
- `iRst_n`  in  1  reset; asynchronous, active-low.
- `iClear`  in  1  one-cycle request to start a clear sweep.
- `iValid`  in  1  pixel strobe; counted only when `oReady` = 1 in the same cycle.
- `iGray`  in  PIX_W  pixel value; bin = `iGray[PIX_W-1 -: BIN_W]`.
- `oReady`  out  1  1 in RUN: pixels accepted.
- `oBusy`  out  1  1 in CLEAR.
- `oDone`  out  1  one-cycle pulse when a sweep completes.
- `iRdAddr`  in  BIN_W  readout bin index.
- `oRdData`  out  CNT_W  registered count of `iRdAddr`.
- `oTotal`  out  TOT_W  accepted pixels since last clear, saturating.

## Operation
- States: CLEAR, RUN. Reset state is CLEAR with sweep address 0.
- CLEAR: writes 0 to bin `sweep_addr` each cycle, address increments by 1; after the write to `NBINS-1`, moves to RUN and pulses `oDone`.
- RUN: `iClear` = 1 -> CLEAR, sweep address reset to 0, `oTotal` reset to 0.
- CLEAR: `iClear` = 1 restarts the sweep at 0 with no `oDone` pulse for the aborted sweep.
- RUN pipeline:
  - S0 (accept): RAM read issued at the bin address.
  - S1: data returns; next = src + 1, saturating at `2**CNT_W-1`.
  - S2: write registered.
- Forwarding source for S1, newest first:
  - S2 write register when valid and same bin.
  - Write committed in the previous cycle when same bin.
  - RAM q otherwise.
- Consequence: N back-to-back pixels to one bin add exactly N.
- Entering CLEAR kills S1/S2. In-flight pixels are dropped and never written.
- `iValid` while `oReady` = 0 is ignored and not counted.
- `oTotal` increments once per accepted pixel and saturates at all-ones.
- The readout port operates in every state. Reads during a sweep return 0 or stale data.

## Timing
- Reset values: `oReady` 0, `oBusy` 1, `oDone` 0, `oRdData` 0, `oTotal` 0. Internal pipeline valids 0.
- Sweep after reset: zero writes occur on the first `NBINS` edges after reset release. `oReady` = 1 and `oDone` = 1 in the following cycle.
- `iClear` sampled high at edge t:
  - `oBusy` = 1 and `oReady` = 0 from t to t+`NBINS`.
  - `oReady` and `oDone` high at t+`NBINS`+1.
- Pixel accepted at edge t:
  - RAM write at edge t+2.
  - Visible on readout when `iRdAddr` is presented from cycle t+3; `oRdData` valid 2 cycles after `iRdAddr` (RAM read plus output register).
- `oTotal` updates at t+1.
- RAM read-during-write on the same address returns old data (read-first). Forwarding covers this case.
- Reset asserted mid-sweep or mid-stream: immediate return to the reset state. The sweep restarts at 0 after release.

## Structure
- Package `hist_pkg`:
  - State enum `hist_state_t` {ST_CLEAR, ST_RUN}.
  - Default parameter constants.
  - Saturating-increment function.
- Sub-module `hist_bin_ram`: `NBINS` x `CNT_W`, one write port, two synchronous read-first read ports, no reset.

## Test plan
- Reset release -> `oBusy` high for 256 cycles. Then `oDone` pulses and `oReady` = 1. Readout of every bin = 0.
- 10 consecutive pixels 0x37 -> bin 0x37 = 10, `oTotal` = 10.
- Alternating 0x05, 0x05, 0x09, 0x05 every cycle for 100 cycles -> bin 5 = 75, bin 9 = 25. Exercises both forwarding distances.
- `CNT_W` = 4, 20 pixels of 0xFF -> bin 0xFF = 15 (saturated). `oTotal` = 20.
- `iClear` pulsed while pixels in flight -> no post-clear nonzero bins. `oDone` exactly 256 cycles after the clear, counted from t+1.
- `iValid` held high during CLEAR -> ignored. `oTotal` = 0 at `oDone`.
